// File: rtl/dma_read_responder_pkg.sv
// Shared types for the DMA read responder slice.
// Optional macro DMA_READ_RESPONDER_JITTER_EN is consumed by the top.
package dma_read_responder_pkg;

   localparam int CLADDR_WIDTH = 42;

   typedef logic [CLADDR_WIDTH-1:0] t_claddr;

   typedef struct packed {
      t_claddr    addr;
      logic [2:0] lines;
   } t_dma_read_req;

   typedef enum logic [1:0] {
      RLEN_1 = 2'b00,
      RLEN_2 = 2'b01,
      RLEN_4 = 2'b11
   } t_dma_rlength;

   typedef enum logic {
      DMARESP_IDLE,
      DMARESP_BURST
   } t_dmaresp_state;

   // The illegal code 2'b10 is served as a single line.
   function automatic logic [2:0] rlen_lines(input logic [1:0] rlen);
      logic [2:0] n;
      case (rlen)
         RLEN_1:  n = 3'd1;
         RLEN_2:  n = 3'd2;
         RLEN_4:  n = 3'd4;
         default: n = 3'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dma_read_req_fifo.sv
// Synchronous request FIFO for the DMA read responder.
// Pushes on full and pops on empty are ignored.
module dma_read_req_fifo
   import dma_read_responder_pkg::*;
#(
   parameter int LOG2_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                push,
   input  t_dma_read_req       push_data,
   input  logic                pop,
   output t_dma_read_req       head,
   output logic [LOG2_DEPTH:0] count,
   output logic                full,
   output logic                empty
);

   localparam int DEPTH = 2 ** LOG2_DEPTH;

   t_dma_read_req         mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = count[LOG2_DEPTH];
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count
                + (LOG2_DEPTH+1)'(do_push)
                - (LOG2_DEPTH+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dma_read_responder.sv
// DMA read responder: request FIFO, burst FSM, BRAM with backdoor.
// Optional DMA_READ_RESPONDER_JITTER_EN: LFSR stalls read issue.
module dma_read_responder
   import dma_read_responder_pkg::*;
#(
   parameter int DATA_WIDTH       = 512,
   parameter int ADDRESS_WIDTH    = 42,
   parameter int LOG2_MEM_DEPTH   = 10,
   parameter int LOG2_REQ_DEPTH   = 4,
   parameter int ALMOSTFULL_SLACK = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      tx_re,
   input  logic [ADDRESS_WIDTH-1:0]  tx_raddr,
   input  logic [1:0]                tx_rlength,
   output logic                      tx_ralmostfull,
   output logic                      rx_rvalid,
   output logic [DATA_WIDTH-1:0]     rx_rdata,
   input  logic                      bd_we,
   input  logic [LOG2_MEM_DEPTH-1:0] bd_addr,
   input  logic [DATA_WIDTH-1:0]     bd_wdata,
   output logic                      err_overflow,
   output logic                      err_bad_length,
   output logic [31:0]               resp_lines
);

   localparam int MEM_DEPTH = 2 ** LOG2_MEM_DEPTH;
   localparam int REQ_DEPTH = 2 ** LOG2_REQ_DEPTH;
   localparam int AF_LEVEL  = REQ_DEPTH - ALMOSTFULL_SLACK;

   t_dma_read_req           push_req;
   t_dma_read_req           head;
   logic [LOG2_REQ_DEPTH:0] fifo_count;
   logic [LOG2_REQ_DEPTH:0] cnt_next;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_pop;
   logic                    push_ok;
   logic                    stall;

   t_dmaresp_state            state, state_n;
   logic [LOG2_MEM_DEPTH-1:0] cur_idx, idx_n;
   logic [1:0]                beat, beat_n;
   logic [2:0]                lines_q, lines_n;
   logic                      last;
   logic                      issue;
   logic [LOG2_MEM_DEPTH-1:0] issue_idx;

   logic                      iss_valid;
   logic [LOG2_MEM_DEPTH-1:0] iss_idx;
   logic                      rd_valid;
   logic [DATA_WIDTH-1:0]     rd_data;
   logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
   logic                      unused_addr_hi;

   assign push_ok        = tx_re && !fifo_full;
   assign push_req.addr  = t_claddr'(tx_raddr);
   assign push_req.lines = rlen_lines(tx_rlength);
   assign unused_addr_hi =
      ^head.addr[CLADDR_WIDTH-1:LOG2_MEM_DEPTH];

   dma_read_req_fifo #(
      .LOG2_DEPTH (LOG2_REQ_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_ok),
      .push_data (push_req),
      .pop       (fifo_pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Almost-full reflects the occupancy left behind by this edge.
   assign cnt_next = fifo_count
                   + (LOG2_REQ_DEPTH+1)'(push_ok)
                   - (LOG2_REQ_DEPTH+1)'(fifo_pop);

`ifdef DMA_READ_RESPONDER_JITTER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr <= 16'hACE1;
      else lfsr <= {lfsr[14:0],
                    lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign last = (({1'b0, beat} + 3'd1) == lines_q);

   always_comb begin
      state_n   = state;
      idx_n     = cur_idx;
      beat_n    = beat;
      lines_n   = lines_q;
      fifo_pop  = 1'b0;
      issue     = 1'b0;
      issue_idx = cur_idx + LOG2_MEM_DEPTH'(beat);
      unique case (state)
         DMARESP_IDLE: begin
            if (!fifo_empty && !stall) begin
               fifo_pop  = 1'b1;
               issue     = 1'b1;
               issue_idx = head.addr[LOG2_MEM_DEPTH-1:0];
               idx_n     = head.addr[LOG2_MEM_DEPTH-1:0];
               lines_n   = head.lines;
               beat_n    = 2'd1;
               if (head.lines != 3'd1) state_n = DMARESP_BURST;
            end
         end
         DMARESP_BURST: begin
            if (!stall) begin
               issue  = 1'b1;
               beat_n = beat + 2'd1;
               if (last) begin
                  // Chain straight into the next request.
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     idx_n    = head.addr[LOG2_MEM_DEPTH-1:0];
                     lines_n  = head.lines;
                     beat_n   = 2'd0;
                  end else begin
                     state_n = DMARESP_IDLE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= DMARESP_IDLE;
         cur_idx        <= '0;
         beat           <= '0;
         lines_q        <= '0;
         iss_valid      <= 1'b0;
         iss_idx        <= '0;
         rd_valid       <= 1'b0;
         rx_rvalid      <= 1'b0;
         rx_rdata       <= '0;
         tx_ralmostfull <= 1'b0;
         err_overflow   <= 1'b0;
         err_bad_length <= 1'b0;
         resp_lines     <= '0;
      end else begin
         state          <= state_n;
         cur_idx        <= idx_n;
         beat           <= beat_n;
         lines_q        <= lines_n;
         iss_valid      <= issue;
         iss_idx        <= issue_idx;
         rd_valid       <= iss_valid;
         rx_rvalid      <= rd_valid;
         if (rd_valid) rx_rdata <= rd_data;
         tx_ralmostfull <= (int'(cnt_next) >= AF_LEVEL);
         if (tx_re && fifo_full) err_overflow <= 1'b1;
         if (tx_re && tx_rlength == 2'b10)
            err_bad_length <= 1'b1;
         if (rx_rvalid) resp_lines <= resp_lines + 32'd1;
      end
   end

   // Read-first: a same-edge backdoor write is not seen by the read.
   always_ff @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_wdata;
      if (iss_valid) rd_data <= mem[iss_idx];
   end

endmodule

// File: tb/tb_dma_read_responder.sv
// Self-checking bench for dma_read_responder.
// Scoreboard of expected lines built from a memory model.
`timescale 1ns/1ps
module tb_dma_read_responder;

   localparam int DW    = 512;
   localparam int AW    = 42;
   localparam int LM    = 10;
   localparam int MEM_N = 1 << LM;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          tx_re = 1'b0;
   logic [AW-1:0] tx_raddr = '0;
   logic [1:0]    tx_rlength = '0;
   logic          tx_ralmostfull;
   logic          rx_rvalid;
   logic [DW-1:0] rx_rdata;
   logic          bd_we = 1'b0;
   logic [LM-1:0] bd_addr = '0;
   logic [DW-1:0] bd_wdata = '0;
   logic          err_overflow;
   logic          err_bad_length;
   logic [31:0]   resp_lines;

   dma_read_responder dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .tx_re          (tx_re),
      .tx_raddr       (tx_raddr),
      .tx_rlength     (tx_rlength),
      .tx_ralmostfull (tx_ralmostfull),
      .rx_rvalid      (rx_rvalid),
      .rx_rdata       (rx_rdata),
      .bd_we          (bd_we),
      .bd_addr        (bd_addr),
      .bd_wdata       (bd_wdata),
      .err_overflow   (err_overflow),
      .err_bad_length (err_bad_length),
      .resp_lines     (resp_lines)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [DW-1:0] mem_m [MEM_N];
   logic [DW-1:0] exp_q [$];
   time         rx_t [$];
   int unsigned lines_m = 0;
   time         t_req;
   time         t0;

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] d;
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Every response line is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rx_rvalid) begin
         logic [DW-1:0] e;
         rx_t.push_back($time);
         checks++;
         if (exp_q.size() == 0) begin
            assert (exp_q.size() != 0) else begin
               failures++;
               $error("FAIL unexpected_beat: got rvalid want none");
            end
         end else begin
            e = exp_q.pop_front();
            assert (rx_rdata === e) else begin
               failures++;
               $error("FAIL rdata: got %h want %h", rx_rdata, e);
            end
         end
      end
   end

   task automatic bd_write(input int idx, input logic [DW-1:0] d);
      bd_we = 1'b1;
      bd_addr = LM'(idx);
      bd_wdata = d;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
      mem_m[idx] = d;
   endtask

   task automatic req(input logic [AW-1:0] a, input logic [1:0] l,
                      input bit accept);
      int n;
      int base;
      n = (l == 2'b11) ? 4 : (l == 2'b01) ? 2 : 1;
      base = int'(a[LM-1:0]);
      tx_re = 1'b1;
      tx_raddr = a;
      tx_rlength = l;
      @(posedge clk);
      t_req = $time;
      #1;
      tx_re = 1'b0;
      if (accept) begin
         for (int i = 0; i < n; i++)
            exp_q.push_back(mem_m[(base + i) % MEM_N]);
         lines_m += n;
      end
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] lens [3];
      lens[0] = 2'b00;
      lens[1] = 2'b01;
      lens[2] = 2'b11;

      #2 reset_n = 1'b0;
      #1;
      chk("rst_af", 64'(tx_ralmostfull), 64'd0);
      chk("rst_rvalid", 64'(rx_rvalid), 64'd0);
      checks++;
      assert (rx_rdata === '0) else begin
         failures++;
         $error("FAIL rst_rdata: got %h want 0", rx_rdata);
      end
      chk("rst_ovf", 64'(err_overflow), 64'd0);
      chk("rst_badlen", 64'(err_bad_length), 64'd0);
      chk("rst_lines", 64'(resp_lines), 64'd0);

      @(posedge clk);
      #1;
      for (int i = 0; i < MEM_N; i++)
         bd_write(i, (i < 16) ? DW'(i) : rand_line());
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single line, minimum latency.
      rx_t.delete();
      req(AW'(5), 2'b00, 1'b1);
      drain(50);
      chk("t1_beats", 64'(rx_t.size()), 64'd1);
      if (rx_t.size() > 0)
         chk("t1_latency", 64'(rx_t[0]), 64'(t_req + 35));
      chk("t1_lines", 64'(resp_lines), 64'd1);

      // Two chained bursts with no bubble.
      rx_t.delete();
      req(AW'(8), 2'b11, 1'b1);
      t0 = t_req;
      req(AW'(2), 2'b01, 1'b1);
      drain(50);
      chk("t2_beats", 64'(rx_t.size()), 64'd6);
      if (rx_t.size() == 6) begin
         chk("t2_latency", 64'(rx_t[0]), 64'(t0 + 35));
         chk("t2_span", 64'(rx_t[5] - rx_t[0]), 64'd50);
      end
      chk("t2_lines", 64'(resp_lines), 64'(lines_m));

      // Burst wrapping past the top of memory.
      rx_t.delete();
      req(AW'(1022), 2'b11, 1'b1);
      drain(50);
      chk("wrap_beats", 64'(rx_t.size()), 64'd4);

      // Illegal length is served as one line and flagged.
      rx_t.delete();
      req(AW'(7), 2'b10, 1'b1);
      drain(50);
      chk("badlen_beats", 64'(rx_t.size()), 64'd1);
      chk("badlen_flag", 64'(err_bad_length), 64'd1);

      // Fill the FIFO with the engine held idle.
      rx_t.delete();
      force dut.fifo_empty = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         req(AW'({$urandom, $urandom}), 2'b00, i <= 16);
         chk($sformatf("ovf_af_%0d", i), 64'(tx_ralmostfull),
             64'(i >= 12));
         if (i >= 15)
            chk($sformatf("ovf_flag_%0d", i), 64'(err_overflow),
                64'(i == 17));
      end
      release dut.fifo_empty;
      drain(200);
      chk("ovf_beats", 64'(rx_t.size()), 64'd16);
      chk("ovf_af_clear", 64'(tx_ralmostfull), 64'd0);
      chk("badlen_sticky", 64'(err_bad_length), 64'd1);

      // Random traffic after refreshing some memory lines.
      for (int i = 0; i < 32; i++)
         bd_write(int'($urandom_range(0, MEM_N-1)), rand_line());
      for (int c = 0; c < 80; c++) begin
         if (!tx_ralmostfull && $urandom_range(0, 2) != 0)
            req(AW'({$urandom, $urandom}),
                lens[$urandom_range(0, 2)], 1'b1);
         else begin
            @(posedge clk);
            #1;
         end
      end
      drain(600);
      chk("rand_lines", 64'(resp_lines), 64'(lines_m));
      chk("ovf_sticky", 64'(err_overflow), 64'd1);

      // Reset in the middle of a burst.
      rx_t.delete();
      req(AW'(100), 2'b11, 1'b1);
      begin
         int c;
         c = 0;
         while (rx_t.size() < 2 && c < 20) begin
            @(negedge clk);
            #1;
            c++;
         end
      end
      chk("mid_wait", 64'(rx_t.size()), 64'd2);
      reset_n = 1'b0;
      #1;
      chk("mid_rvalid", 64'(rx_rvalid), 64'd0);
      chk("mid_lines", 64'(resp_lines), 64'd0);
      chk("mid_ovf", 64'(err_overflow), 64'd0);
      chk("mid_badlen", 64'(err_bad_length), 64'd0);
      exp_q.delete();
      lines_m = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("mid_nobeats", 64'(rx_t.size()), 64'd2);
      chk("mid_empty", 64'(dut.fifo_empty), 64'd1);

      // Memory contents survive reset.
      rx_t.delete();
      req(AW'(5), 2'b00, 1'b1);
      drain(50);
      chk("post_beats", 64'(rx_t.size()), 64'd1);
      chk("post_lines", 64'(resp_lines), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
